i2c_slave_responder: RTL and testbench

Single-address I2C target (responder) for the iCE40 designs, answering the bus driven by the team's I2C master block. Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, acknowledges, and moves bytes between the bus and the local fabric through one-cycle strobes. Supports multi-byte writes, multi-byte reads and repeated START; no clock stretching.

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_line_sync.sv | 58 +++++
 rtl/i2c_slave_responder.sv | 208 ++++++++++++++++++++
 tb/tb_i2c_slave_responder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: responder state encoding, ACK/NACK bit values and
// the majority vote used by the optional line glitch filter.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_BYTE,
    RX_ACK,
    TX_BYTE,
    TX_ACK,
    IGNORE
  } i2c_state_t;

  localparam logic ACK_BIT  = 1'b0;
  localparam logic NACK_BIT = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// One bus line: 2-FF synchronizer, optional 3-sample majority filter
// (I2C_SLAVE_GLITCH_FILTER_EN) and registered rise/fall strobes.
module i2c_line_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;
  logic       clean;
  logic       last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], pin};
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] hist;
  logic       filt;

  // A pulse lasting a single clk never wins the vote of three samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= 2'b11;
      filt <= 1'b1;
    end else begin
      hist <= {hist[0], sync[1]};
      filt <= maj3(sync[1], hist[0], hist[1]);
    end
  end

  assign clean = filt;
`else
  assign clean = sync[1];
`endif

  // level is updated on the same edge as the strobes so they stay aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      last <= clean;
      rise <= clean & ~last;
      fall <= ~clean & last;
    end
  end

  assign level = last;

endmodule

// File: rtl/i2c_slave_responder.sv
// Single-address I2C target with byte strobes to the fabric, no clock stretching.
// Optional SCL/SDA glitch filter: define I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  i2c_state_t state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic [7:0] shreg, shreg_nx;
  logic       full, full_nx;
  logic       rw, rw_nx;
  logic       sda_oe, oe_nx;
  logic [7:0] rx_data_nx;
  logic       rx_valid_nx, tx_req_nx, busy_nx;

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  assign sda = sda_oe ? 1'b0 : 1'bz;

  i2c_line_sync u_scl_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (scl),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (sda),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      shreg    <= 8'h00;
      full     <= 1'b0;
      rw       <= 1'b0;
      sda_oe   <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      shreg    <= shreg_nx;
      full     <= full_nx;
      rw       <= rw_nx;
      sda_oe   <= oe_nx;
      rx_data  <= rx_data_nx;
      rx_valid <= rx_valid_nx;
      tx_req   <= tx_req_nx;
      busy     <= busy_nx;
    end
  end

  // full marks that the 8th rise of the current byte has been seen, so the
  // following fall closes the byte (and the SCL fall right after START is ignored).
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    shreg_nx    = shreg;
    full_nx     = full;
    rw_nx       = rw;
    oe_nx       = sda_oe;
    rx_data_nx  = rx_data;
    rx_valid_nx = 1'b0;
    tx_req_nx   = 1'b0;
    busy_nx     = busy;

    if (stop_det) begin
      state_nx = IDLE;
      oe_nx    = 1'b0;
      busy_nx  = 1'b0;
      full_nx  = 1'b0;
    end else if (start_det) begin
      state_nx = ADDR;
      cnt_nx   = 3'd0;
      full_nx  = 1'b0;
      oe_nx    = 1'b0;
      busy_nx  = 1'b0;
    end else begin
      unique case (state)
        IDLE: ;

        ADDR: begin
          if (scl_rise) begin
            shreg_nx = {shreg[6:0], sda_lvl};
            cnt_nx   = cnt + 3'd1;
            if (cnt == 3'd7) full_nx = 1'b1;
          end else if (scl_fall && full) begin
            full_nx = 1'b0;
            if (shreg[7:1] == SLAVE_ADDR) begin
              state_nx = ADDR_ACK;
              oe_nx    = 1'b1;
              rw_nx    = shreg[0];
              busy_nx  = 1'b1;
            end else begin
              state_nx = IGNORE;
            end
          end
        end

        ADDR_ACK: begin
          if (scl_rise) begin
            tx_req_nx = rw;
          end else if (scl_fall) begin
            cnt_nx = 3'd0;
            if (rw) begin
              state_nx = TX_BYTE;
              shreg_nx = tx_data;
              oe_nx    = ~tx_data[7];
            end else begin
              state_nx = RX_BYTE;
              oe_nx    = 1'b0;
            end
          end
        end

        RX_BYTE: begin
          if (scl_rise) begin
            shreg_nx = {shreg[6:0], sda_lvl};
            cnt_nx   = cnt + 3'd1;
            if (cnt == 3'd7) begin
              full_nx     = 1'b1;
              rx_data_nx  = {shreg[6:0], sda_lvl};
              rx_valid_nx = 1'b1;
            end
          end else if (scl_fall && full) begin
            full_nx  = 1'b0;
            oe_nx    = 1'b1;
            state_nx = RX_ACK;
          end
        end

        RX_ACK: begin
          if (scl_fall) begin
            oe_nx    = 1'b0;
            cnt_nx   = 3'd0;
            state_nx = RX_BYTE;
          end
        end

        TX_BYTE: begin
          if (scl_rise) begin
            cnt_nx = cnt + 3'd1;
            if (cnt == 3'd7) full_nx = 1'b1;
          end else if (scl_fall) begin
            if (full) begin
              full_nx  = 1'b0;
              oe_nx    = 1'b0;
              state_nx = TX_ACK;
            end else begin
              shreg_nx = {shreg[6:0], 1'b0};
              oe_nx    = ~shreg[6];
            end
          end
        end

        TX_ACK: begin
          if (scl_rise) begin
            if (sda_lvl == ACK_BIT) begin
              tx_req_nx = 1'b1;
              full_nx   = 1'b1;
            end else begin
              state_nx = IGNORE;
            end
          end else if (scl_fall && full) begin
            full_nx  = 1'b0;
            cnt_nx   = 3'd0;
            shreg_nx = tx_data;
            oe_nx    = ~tx_data[7];
            state_nx = TX_BYTE;
          end
        end

        IGNORE: ;

        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench for i2c_slave_responder: bit-banged I2C master, table of write
// transactions plus hand-written read, repeated-START, reset and glitch sequences.
module tb_i2c_slave_responder;

  logic       clk;
  logic       reset;
  logic       scl;
  logic       m_low;
  wire        sda_bus;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       busy;

  int tests;
  int fails;
  int rxv_cnt;
  int txr_cnt;
  int tx_idx;
  logic dut_drove;
  logic [7:0] tx_list [0:7];

  typedef struct {
    logic [6:0] addr;
    logic [7:0] data;
    logic       exp_ack;
    logic [7:0] exp_rx;
  } wvec_t;

  wvec_t wv [0:5];

  assign sda_bus = m_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_slave_responder #(.SLAVE_ADDR(7'h42)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl),
    .sda      (sda_bus),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic q();
    repeat (8) @(negedge clk);
  endtask

  task automatic bus_start();
    m_low = 1'b0; scl = 1'b1; q();
    m_low = 1'b1; q();
    scl = 1'b0; q();
  endtask

  task automatic bus_rstart();
    m_low = 1'b0; q();
    scl = 1'b1; q();
    m_low = 1'b1; q();
    scl = 1'b0; q();
  endtask

  task automatic bus_stop();
    m_low = 1'b1; q();
    scl = 1'b1; q();
    m_low = 1'b0; q();
  endtask

  task automatic write_bit(input logic b, input logic glitch);
    m_low = ~b; q();
    scl = 1'b1; q();
    if (glitch) begin
      scl = 1'b0; @(negedge clk);
      scl = 1'b1;
    end
    q();
    scl = 1'b0; q();
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b0; q();
    scl = 1'b1; q();
    b = sda_bus; q();
    scl = 1'b0; q();
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch_pos, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i], i == glitch_pos);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack_bit, 1'b0);
  endtask

  // Monitor: counts strobes, supplies the next read byte on each tx_req and
  // notes any low on SDA that the master did not cause.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid) rxv_cnt++;
      if (tx_req) begin
        txr_cnt++;
        if (tx_idx < 8) begin
          tx_data = tx_list[tx_idx];
          tx_idx++;
        end
      end
      if (sda_bus === 1'b0 && !m_low) dut_drove = 1'b1;
    end
  end

  initial begin
    #600000;
    fails++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    logic       a_ack, d_ack;
    logic [7:0] rd;
    int         rx0, tx0;

    tests = 0; fails = 0; rxv_cnt = 0; txr_cnt = 0; tx_idx = 0;
    dut_drove = 1'b0;
    tx_list[0] = 8'h3C; tx_list[1] = 8'hF0; tx_list[2] = 8'h5A; tx_list[3] = 8'h00;
    tx_list[4] = 8'hFF; tx_list[5] = 8'hFF; tx_list[6] = 8'hFF; tx_list[7] = 8'hFF;
    wv[0] = '{7'h42, 8'hA5, 1'b1, 8'hA5};
    wv[1] = '{7'h43, 8'h5A, 1'b0, 8'hA5};
    wv[2] = '{7'h42, 8'h00, 1'b1, 8'h00};
    wv[3] = '{7'h02, 8'hFF, 1'b0, 8'h00};
    wv[4] = '{7'h42, 8'hFF, 1'b1, 8'hFF};
    wv[5] = '{7'h21, 8'hC3, 1'b0, 8'hFF};

    reset = 1'b1; scl = 1'b1; m_low = 1'b0; tx_data = 8'h00;
    repeat (5) @(negedge clk);
    check("reset_sda", {31'd0, sda_bus}, 32'd1);
    check("reset_rx_data", {24'd0, rx_data}, 32'h00);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_tx_req", {31'd0, tx_req}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    q();

    for (int i = 0; i < 6; i++) begin
      rx0 = rxv_cnt;
      dut_drove = 1'b0;
      bus_start();
      write_byte({wv[i].addr, 1'b0}, -1, a_ack);
      check($sformatf("w%0d_addr_ack", i), {31'd0, a_ack}, {31'd0, ~wv[i].exp_ack});
      write_byte(wv[i].data, -1, d_ack);
      check($sformatf("w%0d_data_ack", i), {31'd0, d_ack}, {31'd0, ~wv[i].exp_ack});
      check($sformatf("w%0d_busy", i), {31'd0, busy}, {31'd0, wv[i].exp_ack});
      check($sformatf("w%0d_rx_valid_cnt", i), rxv_cnt - rx0, {31'd0, wv[i].exp_ack});
      bus_stop();
      q();
      check($sformatf("w%0d_busy_after_stop", i), {31'd0, busy}, 32'd0);
      check($sformatf("w%0d_rx_data", i), {24'd0, rx_data}, {24'd0, wv[i].exp_rx});
      check($sformatf("w%0d_sda_driven", i), {31'd0, dut_drove}, {31'd0, wv[i].exp_ack});
    end

    // Two-byte read: master ACKs the first byte and NACKs the second.
    tx0 = txr_cnt;
    bus_start();
    write_byte(8'h85, -1, a_ack);
    check("rd_addr_ack", {31'd0, a_ack}, 32'd0);
    read_byte(1'b0, rd);
    check("rd_byte0", {24'd0, rd}, 32'h3C);
    read_byte(1'b1, rd);
    check("rd_byte1", {24'd0, rd}, 32'hF0);
    q(); q();
    check("rd_sda_released", {31'd0, sda_bus}, 32'd1);
    check("rd_tx_req_cnt", txr_cnt - tx0, 32'd2);
    check("rd_busy", {31'd0, busy}, 32'd1);
    bus_stop();
    q();
    check("rd_busy_after_stop", {31'd0, busy}, 32'd0);

    // Write then repeated START into a read, no STOP in between.
    rx0 = rxv_cnt;
    bus_start();
    write_byte(8'h84, -1, a_ack);
    check("rs_waddr_ack", {31'd0, a_ack}, 32'd0);
    write_byte(8'h11, -1, d_ack);
    check("rs_data_ack", {31'd0, d_ack}, 32'd0);
    bus_rstart();
    write_byte(8'h85, -1, a_ack);
    check("rs_raddr_ack", {31'd0, a_ack}, 32'd0);
    check("rs_rx_data", {24'd0, rx_data}, 32'h11);
    check("rs_rx_valid_cnt", rxv_cnt - rx0, 32'd1);
    read_byte(1'b1, rd);
    check("rs_read_byte", {24'd0, rd}, 32'h5A);
    check("rs_busy", {31'd0, busy}, 32'd1);
    bus_stop();
    q();

    // Reset while the target drives a 0 data bit.
    bus_start();
    write_byte(8'h85, -1, a_ack);
    check("rst_addr_ack", {31'd0, a_ack}, 32'd0);
    m_low = 1'b0; q();
    scl = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sda_driven_before", {31'd0, sda_bus}, 32'd0);
    reset = 1'b1;
    #1;
    check("rst_sda_released", {31'd0, sda_bus}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'h00);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_tx_req", {31'd0, tx_req}, 32'd0);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    q(); q();

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    // 1-clk SCL low pulse during bit 3 must not shift an extra bit.
    rx0 = rxv_cnt;
    bus_start();
    write_byte(8'h84, -1, a_ack);
    check("gl_addr_ack", {31'd0, a_ack}, 32'd0);
    write_byte(8'h96, 3, d_ack);
    check("gl_data_ack", {31'd0, d_ack}, 32'd0);
    check("gl_rx_data", {24'd0, rx_data}, 32'h96);
    check("gl_rx_valid_cnt", rxv_cnt - rx0, 32'd1);
    bus_stop();
    q();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
